// File: rtl/culsans_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NumPorts requesters.
// A granted port may lock the SRAM for read-modify-write sequences; an idle
// lock is forcibly dropped after LockTimeout cycles. Responses (read data or
// write acknowledge) are routed back to the port that was granted, RdLatency
// cycles after the grant, in grant order.
module culsans_sram_arbiter #(
    parameter int unsigned NumPorts    = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned RdLatency   = 1,
    parameter int unsigned LockTimeout = 256
) (
    input  logic                              clk_i,
    input  logic                              rst,
    input  logic [NumPorts-1:0]               req_i,
    input  logic [NumPorts-1:0]               we_i,
    input  logic [NumPorts-1:0]               lock_i,
    input  logic [NumPorts*AddrWidth-1:0]     addr_i,
    input  logic [NumPorts*DataWidth-1:0]     wdata_i,
    input  logic [NumPorts*(DataWidth/8)-1:0] be_i,
    output logic [NumPorts-1:0]               gnt_o,
    output logic [NumPorts-1:0]               rvalid_o,
    output logic [DataWidth-1:0]              rdata_o,
    output logic                              sram_req_o,
    output logic                              sram_we_o,
    output logic [AddrWidth-1:0]              sram_addr_o,
    output logic [DataWidth-1:0]              sram_wdata_o,
    output logic [(DataWidth/8)-1:0]          sram_be_o,
    input  logic [DataWidth-1:0]              sram_rdata_i,
    output logic                              lock_err_o
);

    localparam int unsigned BeWidth = DataWidth / 8;
    // Keep at least one index bit so the single-port build still elaborates.
    localparam int unsigned IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned CntW    = $clog2(LockTimeout);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e                     lock_q, lock_d;
    logic [IdxW-1:0]                 owner_q, owner_d;
    logic [IdxW-1:0]                 rr_q, rr_d;
    logic [CntW-1:0]                 idle_cnt_q, idle_cnt_d;
    logic [RdLatency-1:0]            pipe_vld_q;
    logic [RdLatency-1:0][IdxW-1:0]  pipe_idx_q;

    logic [IdxW:0]                   pick;
    logic                            gnt_valid;
    logic [IdxW-1:0]                 gnt_idx;

    // Next port after i, wrapping NumPorts-1 back to 0.
    function automatic logic [IdxW-1:0] wrap_inc(input logic [IdxW-1:0] i);
        int unsigned n;
        n = (32'(i) + 32'd1) % NumPorts;
        return IdxW'(n);
    endfunction

    // First requesting port at or after start (circularly); MSB flags a hit.
    function automatic logic [IdxW:0] rr_pick(input logic [NumPorts-1:0] req,
                                              input logic [IdxW-1:0]     start);
        logic [IdxW:0]   res;
        logic [IdxW-1:0] pi;
        int unsigned     p;
        res = '0;
        // Walk from the farthest candidate back to start so the closest one wins.
        for (int k = NumPorts - 1; k >= 0; k--) begin
            p  = (32'(start) + 32'(k)) % NumPorts;
            pi = IdxW'(p);
            if (req[pi]) begin
                res = {1'b1, pi};
            end
        end
        return res;
    endfunction

    // Select the winner: only the owner while locked, round-robin otherwise.
    always_comb begin
        pick = '0;
        if (lock_q == LOCKED) begin
            if (req_i[owner_q]) begin
                pick = {1'b1, owner_q};
            end
        end else begin
            pick = rr_pick(req_i, rr_q);
        end
    end

    // No grant may leave the block while reset is held, even with requests pending.
    assign gnt_valid = rst & pick[IdxW];
    assign gnt_idx   = pick[IdxW-1:0];

    // One-hot grant and AND-OR mux of the granted port's payload onto the SRAM.
    always_comb begin
        gnt_o        = '0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        for (int i = 0; i < NumPorts; i++) begin
            gnt_o[i] = gnt_valid && (gnt_idx == IdxW'(i));
            if (gnt_o[i]) begin
                sram_we_o    = we_i[i];
                sram_addr_o  = addr_i[i*AddrWidth +: AddrWidth];
                sram_wdata_o = wdata_i[i*DataWidth +: DataWidth];
                sram_be_o    = be_i[i*BeWidth +: BeWidth];
            end
        end
    end

    assign sram_req_o = |gnt_o;

    // Lock FSM next state, round-robin pointer update and timeout detection.
    always_comb begin
        lock_d     = lock_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        rr_d       = rr_q;
        lock_err_o = 1'b0;
        unique case (lock_q)
            UNLOCKED: begin
                if (gnt_valid) begin
                    rr_d = wrap_inc(gnt_idx);
                    if (lock_i[gnt_idx]) begin
                        lock_d     = LOCKED;
                        owner_d    = gnt_idx;
                        idle_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (gnt_valid) begin
                    // Only the owner can be granted here; its access always completes.
                    idle_cnt_d = '0;
                    if (!lock_i[owner_q]) begin
                        lock_d = UNLOCKED;
                        rr_d   = wrap_inc(owner_q);
                    end
                end else if (idle_cnt_q == CntW'(LockTimeout - 1)) begin
                    lock_d     = UNLOCKED;
                    idle_cnt_d = '0;
                    rr_d       = wrap_inc(owner_q);
                    lock_err_o = 1'b1;
                end else begin
                    idle_cnt_d = idle_cnt_q + CntW'(1);
                end
            end
            default: begin
                lock_d = UNLOCKED;
            end
        endcase
    end

    // Arbiter and lock state registers.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            lock_q     <= UNLOCKED;
            owner_q    <= '0;
            rr_q       <= '0;
            idle_cnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Response tracking pipe matching the SRAM latency; cleared so reset drops in-flight accesses.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            pipe_vld_q <= '0;
            pipe_idx_q <= '0;
        end else begin
            for (int s = RdLatency - 1; s > 0; s--) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_idx_q[s] <= pipe_idx_q[s-1];
            end
            pipe_vld_q[0] <= gnt_valid;
            pipe_idx_q[0] <= gnt_idx;
        end
    end

    // Route the response strobe to the port that was granted RdLatency cycles ago.
    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            rvalid_o[i] = pipe_vld_q[RdLatency-1] && (pipe_idx_q[RdLatency-1] == IdxW'(i));
        end
    end

    assign rdata_o = pipe_vld_q[RdLatency-1] ? sram_rdata_i : '0;

endmodule

// File: tb/tb_culsans_sram_arbiter.sv
// Bench for culsans_sram_arbiter: table-driven grant vectors with a response
// scoreboard, hand-written lock timeout / data path sequences, and a second
// instance with RdLatency=3 for reset during an in-flight read.
module tb_culsans_sram_arbiter;

    localparam int NP = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A (RdLatency=1) ----------------
    logic              rst_a;
    logic [NP-1:0]     req, we, lock;
    logic [NP*AW-1:0]  addr_flat;
    logic [NP*DW-1:0]  wdata_flat;
    logic [NP*BW-1:0]  be_flat;
    logic [NP-1:0]     gnt, rvalid;
    logic [DW-1:0]     rdata;
    logic              sram_req, sram_we, lock_err;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata, sram_rdata;
    logic [BW-1:0]     sram_be;

    logic [AW-1:0] addr_arr  [NP];
    logic [DW-1:0] wdata_arr [NP];
    logic [BW-1:0] be_arr    [NP];

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign addr_flat[g*AW +: AW]  = addr_arr[g];
        assign wdata_flat[g*DW +: DW] = wdata_arr[g];
        assign be_flat[g*BW +: BW]    = be_arr[g];
    end

    culsans_sram_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .RdLatency(1), .LockTimeout(256)
    ) dut (
        .clk_i(clk), .rst(rst_a), .req_i(req), .we_i(we), .lock_i(lock),
        .addr_i(addr_flat), .wdata_i(wdata_flat), .be_i(be_flat),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata),
        .lock_err_o(lock_err)
    );

    // ---------------- DUT B (RdLatency=3) ----------------
    logic              rst_b;
    logic [NP-1:0]     req_b;
    logic [NP-1:0]     gnt_b, rvalid_b;
    logic [DW-1:0]     rdata_b;
    logic              sram_req_b, sram_we_b, lock_err_b;
    logic [AW-1:0]     sram_addr_b;
    logic [DW-1:0]     sram_wdata_b;
    logic [BW-1:0]     sram_be_b;

    culsans_sram_arbiter #(
        .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .RdLatency(3), .LockTimeout(256)
    ) dut_b (
        .clk_i(clk), .rst(rst_b), .req_i(req_b), .we_i('0), .lock_i('0),
        .addr_i('0), .wdata_i('0), .be_i('0),
        .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .sram_req_o(sram_req_b), .sram_we_o(sram_we_b), .sram_addr_o(sram_addr_b),
        .sram_wdata_o(sram_wdata_b), .sram_be_o(sram_be_b), .sram_rdata_i(64'h5A5A_5A5A_5A5A_5A5A),
        .lock_err_o(lock_err_b)
    );

    // ---------------- SRAM model for DUT A (1-cycle read) ----------------
    logic [DW-1:0] mem [256];
    logic [DW-1:0] sram_rdata_q;
    assign sram_rdata = sram_rdata_q;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) mem[sram_addr[10:3]] <= merge(mem[sram_addr[10:3]], sram_wdata, sram_be);
            else         sram_rdata_q <= mem[sram_addr[10:3]];
        end
    end

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [NP-1:0] oh;
        logic          chk_data;
        logic [DW-1:0] data;
        int            due;
    } resp_t;

    resp_t sb[$];
    resp_t mon_it;

    // Scoreboard: every expected grant must answer exactly one cycle later, nothing else may.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            mon_it = sb.pop_front();
            chk("resp.rvalid", 64'(rvalid), 64'(mon_it.oh));
            if (mon_it.chk_data) chk("resp.rdata", rdata, mon_it.data);
        end else begin
            chk("idle.rvalid", 64'(rvalid), 64'd0);
            chk("idle.rdata", rdata, 64'd0);
        end
    end

    // One cycle on DUT A: drive, push expected response, check grant and SRAM side.
    task automatic step(input string tag, input logic [NP-1:0] r, input logic [NP-1:0] w,
                        input logic [NP-1:0] l, input logic [NP-1:0] eg, input logic ee,
                        input logic cd, input logic [DW-1:0] ed);
        resp_t it;
        int    p;
        req  = r;
        we   = w;
        lock = l;
        if (eg != '0) begin
            it.oh = eg; it.chk_data = cd; it.data = ed; it.due = cyc + 1;
            sb.push_back(it);
        end
        @(negedge clk);
        chk({tag, ".gnt"}, 64'(gnt), 64'(eg));
        chk({tag, ".lock_err"}, 64'(lock_err), 64'(ee));
        chk({tag, ".sram_req"}, 64'(sram_req), 64'(eg != '0));
        if (eg != '0) begin
            p = 0;
            for (int i = 0; i < NP; i++) if (eg[i]) p = i;
            chk({tag, ".sram_addr"}, sram_addr, addr_arr[p]);
            chk({tag, ".sram_we"}, 64'(sram_we), 64'(w[p]));
            if (w[p]) begin
                chk({tag, ".sram_wdata"}, sram_wdata, wdata_arr[p]);
                chk({tag, ".sram_be"}, 64'(sram_be), 64'(be_arr[p]));
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NP-1:0] req;
        logic [NP-1:0] we;
        logic [NP-1:0] lock;
        logic [NP-1:0] gnt;
        logic          err;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        // Round-robin over all four ports, writes on the second lap.
        vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0};
        vecs[5]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0010, 1'b0};
        vecs[6]  = '{4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b0};
        vecs[7]  = '{4'b1111, 4'b1111, 4'b0000, 4'b1000, 1'b0};
        // Idle, sparse requests and pointer wrap.
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[9]  = '{4'b1010, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        vecs[10] = '{4'b1010, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        vecs[11] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0};
        vecs[12] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0};
        // Port 1 locks; ports 0/3 stall; port 1 unlocks; port 3 then port 0.
        vecs[13] = '{4'b1011, 4'b0000, 4'b0010, 4'b0010, 1'b0};
        vecs[14] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[15] = '{4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        vecs[16] = '{4'b1011, 4'b0000, 4'b0000, 4'b0010, 1'b0};
        vecs[17] = '{4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b0};
        vecs[18] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0};

        for (int i = 0; i < 256; i++) mem[i] = '0;
        sram_rdata_q = '0;
        for (int p = 0; p < NP; p++) begin
            addr_arr[p]  = 64'h1008 + 64'(p) * 64'h40;
            wdata_arr[p] = {16'hA000 + 16'(p), 48'h1234_5678_9ABC};
            be_arr[p]    = 8'hF0 | 8'(p);
        end
        req = '0; we = '0; lock = '0; req_b = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        #2;
        rst_a = 1'b0; rst_b = 1'b0;
        req = 4'b1111; lock = 4'b1111; req_b = 4'b1111;

        // Reset state with requests pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst.gnt", 64'(gnt), 64'd0);
            chk("rst.sram_req", 64'(sram_req), 64'd0);
            chk("rst.lock_err", 64'(lock_err), 64'd0);
            chk("rst.gnt_b", 64'(gnt_b), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        lock = '0; req_b = '0;

        for (int i = 0; i < NV; i++) begin
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, vecs[i].lock,
                 vecs[i].gnt, vecs[i].err, 1'b0, '0);
        end

        // Lock timeout: port 0 locks then idles while port 3 waits.
        step("to.lock", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 256; k++) begin
            step($sformatf("to.idle%0d", k), 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                 (k == 256), 1'b0, '0);
        end
        step("to.resume", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, '0);

        // Write by port 1, read back by port 2 at the same address.
        addr_arr[1]  = 64'h8010_0000;
        addr_arr[2]  = 64'h8010_0000;
        wdata_arr[1] = 64'hDEAD_BEEF_0123_4567;
        be_arr[1]    = 8'hFF;
        step("wr.p1", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, '0);
        step("rd.p2", 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567);
        for (int i = 0; i < 3; i++) step("drain", '0, '0, '0, '0, 1'b0, 1'b0, '0);
        chk("sb.empty", 64'(sb.size()), 64'd0);

        // Reset with a read in flight on the RdLatency=3 instance.
        req_b = 4'b0100;
        @(negedge clk);
        chk("rl.gnt", 64'(gnt_b), 64'b0100);
        @(posedge clk);
        #1;
        req_b = '0;
        @(negedge clk);
        chk("rl.inflight", 64'(rvalid_b), 64'd0);
        rst_b = 1'b0;
        req_b = 4'b1001;
        #1;
        chk("rl.rst_gnt", 64'(gnt_b), 64'd0);
        chk("rl.rst_rvalid", 64'(rvalid_b), 64'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        req_b = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rl.dropped%0d", i), 64'(rvalid_b), 64'd0);
        end
        @(posedge clk);
        #1;
        req_b = 4'b1001;
        @(negedge clk);
        chk("rl.first_gnt", 64'(gnt_b), 64'b0001);
        @(posedge clk);
        #1;
        req_b = '0;
        @(negedge clk);
        chk("rl.lat1", 64'(rvalid_b), 64'd0);
        @(negedge clk);
        chk("rl.lat2", 64'(rvalid_b), 64'd0);
        @(negedge clk);
        chk("rl.lat3", 64'(rvalid_b), 64'b0001);
        chk("rl.rdata", rdata_b, 64'h5A5A_5A5A_5A5A_5A5A);

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
